// File: rtl/rain_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rain_pkg : constants and types shared by the nRain generator and gauge.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package rain_pkg;

    localparam int RAIN_PULSE_01MM = 28;
    localparam int RAIN_MAX_01MM   = 99999;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        LOW  = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } rain_gen_state_t;

endpackage
`default_nettype wire

// File: rtl/rain_pulse_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rain_pulse_gen_if : request/status bundle of the nRain pulse generator.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface rain_pulse_gen_if;
    import rain_pkg::*;

    logic        start;
    logic        abort;
    bcd_digit_t  target_hundreds_bcd;
    bcd_digit_t  target_tens_bcd;
    bcd_digit_t  target_units_bcd;
    bcd_digit_t  target_tenths_bcd;
    bcd_digit_t  target_hundredths_bcd;
    logic        nRain;
    logic        busy;
    logic        done;
    logic        error;
    logic        aborted;
    logic [15:0] pulses_sent;
    logic [16:0] residual_01mm;

    modport master (
        output start, abort,
        output target_hundreds_bcd, target_tens_bcd, target_units_bcd,
        output target_tenths_bcd, target_hundredths_bcd,
        input  nRain, busy, done, error, aborted, pulses_sent, residual_01mm
    );

    modport slave (
        input  start, abort,
        input  target_hundreds_bcd, target_tens_bcd, target_units_bcd,
        input  target_tenths_bcd, target_hundredths_bcd,
        output nRain, busy, done, error, aborted, pulses_sent, residual_01mm
    );

endinterface
`default_nettype wire

// File: rtl/rain_bcd_to_bin.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rain_bcd_to_bin : five-cycle sequential BCD accumulator, hundreds first. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rain_bcd_to_bin
    import rain_pkg::*;
(
    input  wire logic             Clock,
    input  wire logic             nReset,
    input  wire logic             load,
    input  wire bcd_digit_t [4:0] digits,
    output logic                  result_valid,
    output logic [16:0]           result,
    output logic [16:0]           partial,
    output logic                  bcd_error
);

    bcd_digit_t [4:0] digit_sr;
    logic [2:0]       count;
    logic             active;
    logic [16:0]      acc;
    logic             err_seen;
    bcd_digit_t       cur_digit;
    logic [16:0]      acc_next;

    assign cur_digit = digit_sr[4];
    assign acc_next  = 17'(acc * 17'd10) + {13'd0, cur_digit};

    // The final digit is folded in combinationally so the caller can branch
    // in the same cycle the last digit is consumed.
    assign result_valid = active && (count == 3'd4);
    assign result       = acc_next;
    assign partial      = acc;
    assign bcd_error    = err_seen || (cur_digit > 4'd9);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            digit_sr <= '0;
            count    <= 3'd0;
            active   <= 1'b0;
            acc      <= 17'd0;
            err_seen <= 1'b0;
        end else if (load) begin
            digit_sr <= digits;
            count    <= 3'd0;
            active   <= 1'b1;
            acc      <= 17'd0;
            err_seen <= 1'b0;
        end else if (active) begin
            digit_sr <= {digit_sr[3:0], 4'h0};
            count    <= count + 3'd1;
            acc      <= acc_next;
            err_seen <= bcd_error;
            if (count == 3'd4)
                active <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rain_pulse_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rain_pulse_gen : turns a ddd.dd mm BCD target into active-low nRain      |
// | pulses, one per 0.28 mm, by repeated subtraction.      Rev 1.0           |
// +--------------------------------------------------------------------------+
module rain_pulse_gen
    import rain_pkg::*;
#(
    parameter int LOW_CYCLES = 4,
    parameter int GAP_CYCLES = 4
)(
    input  wire logic        Clock,
    input  wire logic        nReset,
    rain_pulse_gen_if.slave  bus
);

    localparam logic [16:0] PULSE   = 17'(RAIN_PULSE_01MM);
    localparam logic [15:0] LOW_END = 16'(LOW_CYCLES - 1);
    localparam logic [15:0] GAP_END = 16'(GAP_CYCLES - 1);

    rain_gen_state_t state;
    rain_gen_state_t next_state;
    logic            busy;
    logic            done;
    logic            start_ok;
    logic [15:0]     timer;
    logic [16:0]     remaining;
    logic [16:0]     residual;
    logic [15:0]     pulses_sent;
    logic            nrain;
    logic            error;
    logic            aborted;

    logic            bcd_valid;
    logic [16:0]     bcd_result;
    logic [16:0]     bcd_partial;
    logic            bcd_error;

    assign start_ok = bus.start && !busy;

    rain_bcd_to_bin u_bcd (
        .Clock        (Clock),
        .nReset       (nReset),
        .load         (start_ok),
        .digits       ({bus.target_hundreds_bcd, bus.target_tens_bcd,
                        bus.target_units_bcd, bus.target_tenths_bcd,
                        bus.target_hundredths_bcd}),
        .result_valid (bcd_valid),
        .result       (bcd_result),
        .partial      (bcd_partial),
        .bcd_error    (bcd_error)
    );

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (bus.start) next_state = LOAD;
            LOAD: begin
                if (bus.abort)
                    next_state = DONE;
                else if (bcd_valid)
                    next_state = (bcd_error || (bcd_result < PULSE)) ? DONE : LOW;
            end
            LOW: begin
                if (bus.abort)
                    next_state = DONE;
                else if (timer == LOW_END)
                    next_state = GAP;
            end
            GAP: begin
                if (bus.abort)
                    next_state = DONE;
                else if (timer == GAP_END)
                    next_state = (remaining >= PULSE) ? LOW : DONE;
            end
            DONE:    next_state = bus.start ? LOAD : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            LOAD, LOW, GAP: busy = 1'b1;
            DONE:           done = 1'b1;
            default:        ;
        endcase
    end

    // nRain is registered from next_state so it changes exactly on state entry.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            nrain       <= 1'b1;
            timer       <= 16'd0;
            remaining   <= 17'd0;
            residual    <= 17'd0;
            pulses_sent <= 16'd0;
            error       <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            nrain <= (next_state != LOW);
            timer <= (next_state != state) ? 16'd0 : timer + 16'd1;

            if (start_ok) begin
                pulses_sent <= 16'd0;
                error       <= 1'b0;
                aborted     <= 1'b0;
                residual    <= 17'd0;
            end

            if (next_state == LOW && state != LOW) begin
                pulses_sent <= pulses_sent + 16'd1;
                remaining   <= ((state == LOAD) ? bcd_result : remaining) - PULSE;
            end

            if (next_state == DONE && state != DONE) begin
                aborted <= bus.abort;
                if (bus.abort)
                    residual <= (state == LOAD) ? bcd_partial : remaining;
                else if (state == LOAD) begin
                    error    <= bcd_error;
                    residual <= bcd_error ? 17'd0 : bcd_result;
                end else
                    residual <= remaining;
            end
        end
    end

    assign bus.nRain         = nrain;
    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.error         = error;
    assign bus.aborted       = aborted;
    assign bus.pulses_sent   = pulses_sent;
    assign bus.residual_01mm = residual;

endmodule
`default_nettype wire
